// File: rtl/vga_pkg.sv
// Shared frame-buffer geometry, pixel layout and slot encoding
// for the VGA scanout / drawing-port RAM arbiter.
package vga_pkg;

    localparam int HPIXELS   = 640;
    localparam int VPIXELS   = 480;
    localparam int FB_WORDS  = HPIXELS * VPIXELS;
    localparam int FB_ADDR_W = 19;

    localparam int PIX_R = 0;
    localparam int PIX_G = 1;
    localparam int PIX_B = 2;

    typedef enum logic [1:0] {
        SLOT_IDLE,
        SLOT_SCAN,
        SLOT_WRITE
    } slot_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; no full bypass, so a push
// is refused while full even if a pop happens in the same clk.
module sync_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 8,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q;
    logic [PW-1:0]    rptr_q;
    logic [LVL_W-1:0] cnt_q;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (cnt_q == LVL_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign level   = cnt_q;
    assign dout    = mem_q[rptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_ok)
                wptr_q <= wptr_q + 1'b1;
            if (pop_ok)
                rptr_q <= rptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wptr_q] <= din;
    end

endmodule

// File: rtl/vram_arbiter.sv
// Frame-buffer RAM arbiter: scanout reads win, queued writes fill gaps.
// Define DOUBLE_BUFFER_EN for two banks swapped at frame tick.
module vram_arbiter #(
    parameter int HPIXELS  = vga_pkg::HPIXELS,
    parameter int VPIXELS  = vga_pkg::VPIXELS,
    parameter int ADDR_W   = vga_pkg::FB_ADDR_W,
    parameter int WQ_DEPTH = 8,
    parameter int LVL_W    = $clog2(WQ_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ptick,
    input  logic              active,
    input  logic [9:0]        xpos,
    input  logic [9:0]        ypos,
    input  logic              ftick,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [2:0]        wr_data,
    output logic              wr_ready,
`ifdef DOUBLE_BUFFER_EN
    input  logic              swap_req,
    output logic              front_bank,
    output logic [ADDR_W:0]   mem_addr,
`else
    output logic [ADDR_W-1:0] mem_addr,
`endif
    output logic              mem_we,
    output logic [2:0]        mem_wdata,
    input  logic [2:0]        mem_rdata,
    output logic [2:0]        pixel_rgb,
    output logic [LVL_W-1:0]  wq_level,
    output logic              err_oob
);

    import vga_pkg::*;

    localparam int DW = ADDR_W + 3;
    localparam logic [ADDR_W-1:0] FB_LIMIT =
        ADDR_W'(HPIXELS * VPIXELS);

    slot_e                 slot;
    logic [DW-1:0]         head;
    logic                  q_full;
    logic                  q_empty;
    logic [ADDR_W-1:0]     head_addr;
    logic [2:0]            head_data;
    logic [ADDR_W-1:0]     scan_addr;
    logic [$bits(mem_addr)-1:0] scan_full;
    logic [$bits(mem_addr)-1:0] write_full;
    logic [$bits(mem_addr)-1:0] addr_q;
    logic                  rd_pend_q;
    logic [2:0]            pix_q;
    logic [2:0]            pix_d;

    assign wr_ready  = !q_full;
    assign pixel_rgb = pix_q;
    assign {head_addr, head_data} = head;

    // y*640 + x as two shifts and an add
    assign scan_addr = (ADDR_W'(ypos) << 9)
                     + (ADDR_W'(ypos) << 7)
                     + ADDR_W'(xpos);

`ifdef DOUBLE_BUFFER_EN
    logic front_q;
    logic swap_pend_q;

    assign front_bank = front_q;
    assign scan_full  = {front_q, scan_addr};
    assign write_full = {~front_q, head_addr};

    always_ff @(posedge clk) begin
        if (reset) begin
            front_q     <= 1'b0;
            swap_pend_q <= 1'b0;
        end else if (ftick && (swap_pend_q || swap_req)) begin
            front_q     <= ~front_q;
            swap_pend_q <= 1'b0;
        end else if (swap_req) begin
            swap_pend_q <= 1'b1;
        end
    end
`else
    logic unused_ftick;

    assign unused_ftick = ftick;
    assign scan_full    = scan_addr;
    assign write_full   = head_addr;
`endif

    sync_fifo #(
        .WIDTH (DW),
        .DEPTH (WQ_DEPTH),
        .LVL_W (LVL_W)
    ) u_wq (
        .clk   (clk),
        .reset (reset),
        .push  (wr_valid && !q_full),
        .pop   (slot == SLOT_WRITE),
        .din   ({wr_addr, wr_data}),
        .dout  (head),
        .full  (q_full),
        .empty (q_empty),
        .level (wq_level)
    );

    // Reset abandons the slot so no pop or RAM write leaks through
    always_comb begin
        slot = SLOT_IDLE;
        if (!reset) begin
            if (!ptick && active)
                slot = SLOT_SCAN;
            else if (!q_empty)
                slot = SLOT_WRITE;
        end
    end

    always_comb begin
        mem_addr  = addr_q;
        mem_we    = 1'b0;
        mem_wdata = head_data;
        err_oob   = 1'b0;
        unique case (slot)
            SLOT_SCAN: begin
                mem_addr = scan_full;
            end
            SLOT_WRITE: begin
                mem_addr = write_full;
                mem_we   = (head_addr < FB_LIMIT);
                err_oob  = !(head_addr < FB_LIMIT);
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        pix_d = pix_q;
        if (rd_pend_q)
            pix_d = mem_rdata;
        else if (!ptick && !active)
            pix_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend_q <= 1'b0;
            pix_q     <= '0;
            addr_q    <= '0;
        end else begin
            rd_pend_q <= (slot == SLOT_SCAN);
            pix_q     <= pix_d;
            addr_q    <= mem_addr;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural sync-read RAM.
// Covers the DOUBLE_BUFFER_EN bank swap when that macro is defined.
module tb_vram_arbiter;

    localparam int ADDR_W = 19;
    localparam int LVL_W  = 4;
`ifdef DOUBLE_BUFFER_EN
    localparam int AW   = ADDR_W + 1;
    localparam int WOFF = 1 << ADDR_W;
`else
    localparam int AW   = ADDR_W;
    localparam int WOFF = 0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              ptick = 1'b0;
    logic              active = 1'b0;
    logic [9:0]        xpos = '0;
    logic [9:0]        ypos = '0;
    logic              ftick = 1'b0;
    logic              wr_valid = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [2:0]        wr_data = '0;
    logic              wr_ready;
    logic [AW-1:0]     mem_addr;
    logic              mem_we;
    logic [2:0]        mem_wdata;
    logic [2:0]        mem_rdata = '0;
    logic [2:0]        pixel_rgb;
    logic [LVL_W-1:0]  wq_level;
    logic              err_oob;
`ifdef DOUBLE_BUFFER_EN
    logic              swap_req = 1'b0;
    logic              front_bank;
`endif

    bit [2:0] ram [int];
    int       checks = 0;
    int       failures = 0;
    int       pi = 0;
    int       wi = 0;
    int       pend = 0;
    bit       feed = 1'b0;
    int       ea [32];
    logic [2:0] ed [32];

    always #5 clk = ~clk;

    vram_arbiter #(
        .WQ_DEPTH (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ptick      (ptick),
        .active     (active),
        .xpos       (xpos),
        .ypos       (ypos),
        .ftick      (ftick),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
`ifdef DOUBLE_BUFFER_EN
        .swap_req   (swap_req),
        .front_bank (front_bank),
`endif
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .pixel_rgb  (pixel_rgb),
        .wq_level   (wq_level),
        .err_oob    (err_oob)
    );

    function automatic logic [2:0] rd(input int a);
        return ram.exists(a) ? ram[a] : 3'd0;
    endfunction

    always @(posedge clk) begin
        mem_rdata <= rd(int'(mem_addr));
        if (mem_we === 1'b1)
            ram[int'(mem_addr)] = mem_wdata;
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic step();
        bit acc;
        if (feed) begin
            wr_valid = (pi < pend);
            if (pi < 32) begin
                wr_addr = ADDR_W'(ea[pi]);
                wr_data = ed[pi];
            end
        end
        #1;
        if (mem_we === 1'b1) begin
            chk("we_in_scan", 32'(!ptick && active), 32'd0);
            if (wi < 32) begin
                chk("wr_order_addr",
                    32'(mem_addr[ADDR_W-1:0]), ea[wi]);
                chk("wr_order_data", 32'(mem_wdata), 32'(ed[wi]));
            end
            wi++;
        end
        acc = feed && wr_valid && wr_ready;
        @(negedge clk);
        if (acc)
            pi++;
    endtask

    initial begin
        ram[1285] = 3'b101;
        @(negedge clk);
        step();
        step();
        chk("rst_level", 32'(wq_level), 32'd0);
        chk("rst_ready", 32'(wr_ready), 32'd1);
        chk("rst_pix", 32'(pixel_rgb), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_oob", 32'(err_oob), 32'd0);
        reset = 1'b0;

        // single scan read of (5,2)
        ptick = 0; active = 1; xpos = 10'd5; ypos = 10'd2;
        #1;
        chk("scan_addr", 32'(mem_addr[ADDR_W-1:0]), 32'd1285);
        chk("scan_we", 32'(mem_we), 32'd0);
        step();
        ptick = 1;
        #1;
        chk("idle_hold", 32'(mem_addr[ADDR_W-1:0]), 32'd1285);
        step();
        chk("scan_pix", 32'(pixel_rgb), 32'd5);

        // burst of 12 writes, queue filled behind scan slots
        for (int i = 0; i < 12; i++) begin
            ea[i] = 1000 + 7 * i;
            ed[i] = 3'((i % 7) + 1);
        end
        pi = 0; wi = 0; pend = 12; feed = 1;
        ptick = 0; active = 1;
        repeat (8) step();
        chk("full_level", 32'(wq_level), 32'd8);
        chk("full_ready", 32'(wr_ready), 32'd0);
        step();
        chk("full_hold", 32'(wq_level), 32'd8);
        for (int k = 0; k < 60 && wi < 12; k++) begin
            ptick = ~ptick;
            step();
        end
        feed = 0; wr_valid = 0;
        chk("burst_count", wi, 32'd12);
        chk("burst_level", 32'(wq_level), 32'd0);
        for (int i = 0; i < 12; i++)
            chk("burst_ram", 32'(rd(WOFF + ea[i])), 32'(ed[i]));

        // blanking drain: one pop per clk
        for (int i = 12; i < 20; i++) begin
            ea[i] = 2000 + i;
            ed[i] = 3'((i * 5) % 8);
        end
        pend = 20; feed = 1;
        ptick = 0; active = 1;
        repeat (8) step();
        feed = 0; wr_valid = 0;
        chk("blank_fill", 32'(wq_level), 32'd8);
        active = 0;
        for (int k = 0; k < 8; k++) begin
            ptick = ~ptick;
            #1;
            chk("blank_we", 32'(mem_we), 32'd1);
            step();
        end
        chk("blank_level", 32'(wq_level), 32'd0);
        chk("blank_pix", 32'(pixel_rgb), 32'd0);
        ptick = ~ptick;
        #1;
        chk("blank_empty_we", 32'(mem_we), 32'd0);
        step();

        // out-of-range entry followed by a valid one
        ea[20] = 3000; ed[20] = 3'd6;
        ptick = 0; active = 1;
        wr_valid = 1; wr_addr = 19'd307200; wr_data = 3'd7;
        step();
        wr_addr = 19'd3000; wr_data = 3'd6;
        step();
        wr_valid = 0;
        active = 0; ptick = 1;
        #1;
        chk("oob_pulse", 32'(err_oob), 32'd1);
        chk("oob_we", 32'(mem_we), 32'd0);
        step();
        ptick = 0;
        #1;
        chk("oob_clear", 32'(err_oob), 32'd0);
        chk("oob_next_we", 32'(mem_we), 32'd1);
        step();
        chk("oob_ram", 32'(rd(WOFF + 3000)), 32'd6);
        chk("oob_skip", 32'(rd(WOFF + 307200)), 32'd0);
        chk("oob_level", 32'(wq_level), 32'd0);

        // reset with five entries queued
        for (int i = 21; i < 26; i++) begin
            ea[i] = 4000 + i;
            ed[i] = 3'(i % 8);
        end
        pi = 21; pend = 26; feed = 1;
        ptick = 0; active = 1;
        repeat (5) step();
        feed = 0; wr_valid = 0;
        chk("rq_level", 32'(wq_level), 32'd5);
        chk("rq_pix_pre", 32'(pixel_rgb), 32'd5);
        reset = 1; ptick = 1; active = 1;
        #1;
        chk("rq_we_in_rst", 32'(mem_we), 32'd0);
        step();
        reset = 0; ptick = 0; active = 0;
        #1;
        chk("rq_level0", 32'(wq_level), 32'd0);
        chk("rq_ready", 32'(wr_ready), 32'd1);
        chk("rq_pix", 32'(pixel_rgb), 32'd0);
        chk("rq_we", 32'(mem_we), 32'd0);
        repeat (4) begin
            ptick = ~ptick;
            step();
        end
        chk("rq_lost", 32'(rd(WOFF + ea[21])), 32'd0);
        chk("rq_level_after", 32'(wq_level), 32'd0);

`ifdef DOUBLE_BUFFER_EN
        chk("db_rst", 32'(front_bank), 32'd0);
        swap_req = 1;
        step();
        swap_req = 0;
        chk("db_pend", 32'(front_bank), 32'd0);
        step();
        step();
        ftick = 1;
        step();
        ftick = 0;
        chk("db_swap", 32'(front_bank), 32'd1);
        ea[21] = 50; ed[21] = 3'd3;
        ptick = 0; active = 1; xpos = 10'd5; ypos = 10'd2;
        wr_valid = 1; wr_addr = 19'd50; wr_data = 3'd3;
        #1;
        chk("db_scan_msb", 32'(mem_addr[ADDR_W]), 32'd1);
        chk("db_scan_lo", 32'(mem_addr[ADDR_W-1:0]), 32'd1285);
        step();
        wr_valid = 0;
        ptick = 1;
        #1;
        chk("db_wr_msb", 32'(mem_addr[ADDR_W]), 32'd0);
        chk("db_wr_we", 32'(mem_we), 32'd1);
        step();
        chk("db_ram", 32'(rd(50)), 32'd3);
        swap_req = 1; ftick = 1;
        step();
        swap_req = 0; ftick = 0;
        chk("db_same_clk", 32'(front_bank), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port 3-bit-per-pixel frame-buffer RAM (640x480 words) between two users:
  - VGA scanout reads, driven by the timing generator's ptick/active/xpos/ypos.
  - A drawing-side write port, buffered through a small write queue.
- Scanout has absolute priority. Writes drain only in slots scanout does not need.
- The registered pixel result drives the timing generator's pixel_rgb input.

Parameters:
- HPIXELS, 640, visible pixels per line.
- VPIXELS, 480, visible lines per frame.
- ADDR_W, 19, frame-buffer word address width (HPIXELS*VPIXELS <= 2**ADDR_W).
- WQ_DEPTH, 8, write-queue entries; must be a power of two, minimum 2.
- LVL_W, $clog2(WQ_DEPTH)+1, width of the queue level output.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high.
- ptick  in  1  pixel-rate enable from the timing generator (high every other clk).
- active  in  1  current position is inside the visible area.
- xpos  in  10  current pixel column.
- ypos  in  10  current line.
- ftick  in  1  frame tick; one-clk pulse on entering vertical blanking.
- wr_valid  in  1  write request.
- wr_addr  in  ADDR_W  linear pixel address, y*HPIXELS+x.
- wr_data  in  3  pixel value {b,g,r}.
- wr_ready  out  1  queue can accept a request.
- mem_addr  out  ADDR_W  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  3  RAM write data.
- mem_rdata  in  3  RAM read data; synchronous read, valid the clk after the address is presented.
- pixel_rgb  out  3  registered scanout pixel.
- wq_level  out  LVL_W  current queue occupancy.
- err_oob  out  1  one-clk pulse when an out-of-range write is discarded.

Behaviour:
- Reset (synchronous, active-high): queue flushed, wq_level=0, wr_ready=1, pixel_rgb=0, mem_we=0, err_oob=0, read-pending flag cleared.
- Slot decision, each clk:
  - SCAN when ptick==0 && active==1. mem_addr = ypos*HPIXELS + xpos, computed as (ypos<<9)+(ypos<<7)+xpos, zero-extended to ADDR_W. mem_we=0.
  - WRITE otherwise, if the queue is non-empty. Pop the head entry and drive mem_addr/mem_wdata from it.
    - If head address < HPIXELS*VPIXELS: mem_we=1.
    - If not: mem_we=0, entry still popped, err_oob=1 for that clk.
  - IDLE otherwise: mem_we=0, mem_addr holds its last value.
- Read latency:
  - A SCAN in clk N sets rd_pend. In clk N+1, pixel_rgb <= mem_rdata at the clk edge.
  - pixel_rgb is therefore valid from clk N+2 and held until the next capture.
  - When a ptick==0 clk has active==0, pixel_rgb <= 0 at that edge (blanking is black).
- Write queue:
  - Synchronous FIFO. Push when wr_valid && wr_ready; wr_ready = !full, with no full-bypass.
  - Simultaneous push and pop are legal at any level below full; the level is unchanged.
  - Writes are applied in push order.
  - wr_addr/wr_data never reach mem_* combinationally; the minimum enqueue-to-RAM latency is 1 clk.
- Bandwidth: at least 1 write per 2 clks during active video; 1 per clk during blanking.
- mem_we is never asserted in a SCAN slot.
- Reset mid-frame or mid-drain: the pending pop is abandoned and queued writes are lost. Scanout resumes with the next ptick==0 clk.

Optional Feature:
- Macro DOUBLE_BUFFER_EN.
- When defined:
  - Added ports: input swap_req (1 bit) and output front_bank (1 bit). mem_addr widens to ADDR_W+1; the MSB selects the bank.
  - SCAN reads use bank front_bank; WRITE uses bank ~front_bank.
  - A swap_req pulse sets swap_pend. On ftick with swap_pend=1, front_bank toggles and swap_pend clears.
  - swap_req and ftick in the same clk both take effect: the swap happens at that ftick.
  - Reset: front_bank=0, swap_pend=0.
- When undefined: single bank, no extra ports, mem_addr is ADDR_W bits.

Decomposition:
- Package vga_pkg:
  - HPIXELS, VPIXELS, FB_WORDS=307200, FB_ADDR_W=19.
  - Slot enum {SLOT_IDLE, SLOT_SCAN, SLOT_WRITE}.
  - Bit positions for the {b,g,r} pixel layout.
- Sub-module sync_fifo: parameterised width/depth; push/pop/full/empty/level; synchronous reset. Instantiated for the write queue at width ADDR_W+3.

Test Plan:
- Active video, xpos=5, ypos=2, ptick=0, RAM preloaded word 1285=3'b101 -> mem_addr=1285, mem_we=0; pixel_rgb=3'b101 two clks later.
- Burst of 12 writes during active video, WQ_DEPTH=8 -> wr_ready drops at wq_level=8; all 12 words land in order; mem_we only in ptick==1 clks; final RAM contents match.
- Writes during blanking (active=0) -> one pop per clk; 8 entries drain in 8 clks; pixel_rgb=0.
- Write with wr_addr=307200 -> no RAM write, err_oob pulses 1 clk, queue advances to the next entry.
- Reset asserted with wq_level=5 -> next clk wq_level=0, wr_ready=1, pixel_rgb=0, mem_we=0.
- DOUBLE_BUFFER_EN: swap_req mid-frame, then ftick -> front_bank 0->1 at the ftick edge; SCAN mem_addr MSB=1 and WRITE MSB=0 afterwards.
